// File: rtl/avmm_arbiter.sv
// -----------------------------------------------------------------------------
// avmm_arbiter
//
// Round-robin arbiter that lets two Avalon-MM masters share one slave port.
// Only one transaction is in flight at a time. The granted master sees the
// slave's waitrequest/readdata directly. The other master is held in
// waitrequest. A slave that stalls a granted transaction for TIMEOUT
// consecutive cycles is abandoned: the master completes with ERROR_DATA and a
// sticky flag records the event.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   m0_* / m1_*         master ports (address, read, write, writedata in;
//                       readdata, waitrequest out)
//   s0_*                slave port (address, read, write, writedata out;
//                       readdata, waitrequest in)
//   timeout_flag        sticky, set by any abort, cleared only by reset
//   abort_master        index of the master in the most recent abort
// -----------------------------------------------------------------------------
module avmm_arbiter #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    TIMEOUT    = 1024,
   parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_WIDTH-1:0] m0_writedata,
   output logic [DATA_WIDTH-1:0] m0_readdata,
   output logic                  m0_waitrequest,

   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_WIDTH-1:0] m1_writedata,
   output logic [DATA_WIDTH-1:0] m1_readdata,
   output logic                  m1_waitrequest,

   output logic [ADDR_WIDTH-1:0] s0_address,
   output logic                  s0_read,
   output logic                  s0_write,
   output logic [DATA_WIDTH-1:0] s0_writedata,
   input  logic [DATA_WIDTH-1:0] s0_readdata,
   input  logic                  s0_waitrequest,

   output logic                  timeout_flag,
   output logic                  abort_master
);

   // A zero TIMEOUT still needs a legal (1-bit) counter; it is simply unused.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      ABORT  = 2'd3
   } state_t;

   state_t           state_reg;
   logic             last_reg;   // last granted master; also the owner in GRANT/ABORT
   logic [CNT_W-1:0] cnt_reg;    // consecutive stalled grant cycles

   // Master-side signals gathered into indexable form.
   logic [1:0]            rd;
   logic [1:0]            wr;
   logic [1:0]            req;
   logic [1:0]            granted;
   logic [1:0]            aborting;
   logic [1:0]            wait_out;
   logic [ADDR_WIDTH-1:0] addr      [2];
   logic [DATA_WIDTH-1:0] wdata     [2];
   logic [DATA_WIDTH-1:0] rdata_out [2];
   logic                  grant_any;

   assign rd       = {m1_read,  m0_read};
   assign wr       = {m1_write, m0_write};
   assign addr[0]  = m0_address;
   assign addr[1]  = m1_address;
   assign wdata[0] = m0_writedata;
   assign wdata[1] = m1_writedata;

   // Outputs are gated by reset so the slave strobe drops in the same cycle
   // reset rises, even in the middle of a transaction.
   assign grant_any = !reset && (state_reg == GRANT0 || state_reg == GRANT1);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         localparam state_t GSTATE = (gi == 0) ? GRANT0 : GRANT1;

         assign req[gi]      = rd[gi] | wr[gi];
         assign granted[gi]  = !reset && (state_reg == GSTATE);
         assign aborting[gi] = !reset && (state_reg == ABORT) && (last_reg == 1'(gi));

         assign wait_out[gi]  = granted[gi] ? s0_waitrequest : !aborting[gi];
         assign rdata_out[gi] = granted[gi]  ? s0_readdata :
                                aborting[gi] ? ERROR_DATA  : '0;
      end
   endgenerate

   assign m0_waitrequest = wait_out[0];
   assign m1_waitrequest = wait_out[1];
   assign m0_readdata    = rdata_out[0];
   assign m1_readdata    = rdata_out[1];

   // Slave-side mux. Read+write together is a write; read is suppressed.
   always_comb begin
      s0_address   = '0;
      s0_writedata = '0;
      s0_read      = 1'b0;
      s0_write     = 1'b0;
      if (grant_any) begin
         s0_address   = addr[last_reg];
         s0_writedata = wdata[last_reg];
         s0_write     = wr[last_reg];
         s0_read      = rd[last_reg] & ~wr[last_reg];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         last_reg     <= 1'b1;
         cnt_reg      <= '0;
         timeout_flag <= 1'b0;
         abort_master <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // m0 wins when it is alone, or when both request and m1 went last.
               if (req[0] && (!req[1] || last_reg)) begin
                  state_reg <= GRANT0;
                  last_reg  <= 1'b0;
                  cnt_reg   <= '0;
               end else if (req[1]) begin
                  state_reg <= GRANT1;
                  last_reg  <= 1'b1;
                  cnt_reg   <= '0;
               end
            end

            GRANT0, GRANT1: begin
               // A dropped request is a protocol violation; just release the slave.
               if (!req[last_reg] || !s0_waitrequest) begin
                  state_reg <= IDLE;
               end else if (TIMEOUT > 0 && cnt_reg == CNT_LAST) begin
                  state_reg    <= ABORT;
                  timeout_flag <= 1'b1;
                  abort_master <= last_reg;
               end
               if (s0_waitrequest && cnt_reg != CNT_MAX) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            ABORT: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avmm_arbiter.sv
`timescale 1ns/1ps
module tb_avmm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] s0_address, s0_writedata, s0_readdata;
   logic        s0_read, s0_write, s0_waitrequest;
   logic        timeout_flag, abort_master;

   always #5 clk = ~clk;

   avmm_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT   (4),
      .ERROR_DATA(32'hDEADBEEF)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .m0_address    (m0_address),
      .m0_read       (m0_read),
      .m0_write      (m0_write),
      .m0_writedata  (m0_writedata),
      .m0_readdata   (m0_readdata),
      .m0_waitrequest(m0_waitrequest),
      .m1_address    (m1_address),
      .m1_read       (m1_read),
      .m1_write      (m1_write),
      .m1_writedata  (m1_writedata),
      .m1_readdata   (m1_readdata),
      .m1_waitrequest(m1_waitrequest),
      .s0_address    (s0_address),
      .s0_read       (s0_read),
      .s0_write      (s0_write),
      .s0_writedata  (s0_writedata),
      .s0_readdata   (s0_readdata),
      .s0_waitrequest(s0_waitrequest),
      .timeout_flag  (timeout_flag),
      .abort_master  (abort_master)
   );

   // ---------------- slave model ----------------
   int stall_n   = 0;   // wait states per transaction
   bit hang      = 1'b0; // stall forever
   int stall_cnt = 0;

   assign s0_waitrequest = (s0_read | s0_write) && (hang || stall_cnt < stall_n);
   assign s0_readdata    = (s0_address == 32'h10) ? 32'h12345678 : (32'hC0DE0000 | s0_address);

   always @(posedge clk)
      stall_cnt <= ((s0_read | s0_write) && s0_waitrequest) ? stall_cnt + 1 : 0;

   // ---------------- bookkeeping ----------------
   int cyc = 0;
   int rd_cyc = 0;
   int wr_cyc = 0;
   int issue_cyc [2];
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (s0_read)  rd_cyc <= rd_cyc + 1;
      if (s0_write) wr_cyc <= wr_cyc + 1;
   end

   typedef struct {
      int          m;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t exp_q [$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void fail_line(string name, string msg);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, msg);
   endfunction

   function automatic void push(int m, bit wr, logic [31:0] addr, logic [31:0] data, int lat);
      exp_t e;
      e.m = m; e.wr = wr; e.addr = addr; e.data = data; e.lat = lat;
      exp_q.push_back(e);
   endfunction

   function automatic logic wait_of(int m);
      return (m != 0) ? m1_waitrequest : m0_waitrequest;
   endfunction

   function automatic logic req_of(int m);
      return (m != 0) ? (m1_read | m1_write) : (m0_read | m0_write);
   endfunction

   function automatic logic [31:0] rdata_of(int m);
      return (m != 0) ? m1_readdata : m0_readdata;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!reset) begin
         for (int m = 0; m < 2; m++) begin
            if (req_of(m) && !wait_of(m)) begin
               if (exp_q.size() == 0) begin
                  fail_line("unexpected_completion", $sformatf("m%0d completed with nothing expected", m));
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  $display("txn m%0d %s addr=%h data=%h lat=%0d", m, e.wr ? "wr" : "rd",
                           e.addr, e.wr ? s0_writedata : rdata_of(m), cyc - issue_cyc[m]);
                  chk("master", m, e.m);
                  chk($sformatf("m%0d_latency", m), cyc - issue_cyc[m], e.lat);
                  if (e.wr) begin
                     chk($sformatf("m%0d_s0_writedata", m), s0_writedata, e.data);
                     chk($sformatf("m%0d_s0_address", m), s0_address, e.addr);
                  end else begin
                     chk($sformatf("m%0d_readdata", m), rdata_of(m), e.data);
                  end
                  chk($sformatf("m%0d_other_wait", m), wait_of(1 - m), 1);
                  chk($sformatf("m%0d_other_rdata", m), rdata_of(1 - m), 0);
               end
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input int m, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      if (m == 0) begin
         m0_read = r; m0_write = w; m0_address = a; m0_writedata = d;
      end else begin
         m1_read = r; m1_write = w; m1_address = a; m1_writedata = d;
      end
   endtask

   // Called just after a rising edge; holds the request until waitrequest is low.
   task automatic run_master(input int m, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      bit done;
      done = 1'b0;
      issue_cyc[m] = cyc;
      drive(m, r, w, a, d);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!wait_of(m)) done = 1'b1;
      end
      if (!done) fail_line($sformatf("m%0d_handshake", m), "no completion within 40 cycles");
      @(posedge clk); #1;
      drive(m, 0, 0, 0, 0);
   endtask

   task automatic pair();
      @(posedge clk); #1;
      fork
         run_master(0, 1'b0, 1'b1, 32'h1, 32'hAA);
         run_master(1, 1'b1, 1'b0, 32'h2, 32'h0);
      join
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rd0, wr0;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_s0_read", s0_read, 0);
      chk("rst_s0_write", s0_write, 0);
      chk("rst_timeout_flag", timeout_flag, 0);
      chk("rst_abort_master", abort_master, 0);

      // Simultaneous after reset: last=1 so m0 first, m1 after one IDLE cycle
      push(0, 1'b1, 32'h1, 32'hAA, 1);
      push(1, 1'b0, 32'h2, 32'hC0DE0002, 3);
      pair();

      // Single zero-wait read by m0
      @(posedge clk); #1;
      rd0 = rd_cyc;
      push(0, 1'b0, 32'h10, 32'h12345678, 1);
      run_master(0, 1'b1, 1'b0, 32'h10, 32'h0);
      chk("single_read_strobe_cycles", rd_cyc - rd0, 1);

      // Simultaneous again with last=0: m1 first
      push(1, 1'b0, 32'h2, 32'hC0DE0002, 1);
      push(0, 1'b1, 32'h1, 32'hAA, 3);
      pair();

      // Read with 3 slave wait states
      stall_n = 3;
      @(posedge clk); #1;
      push(0, 1'b0, 32'h10, 32'h12345678, 4);
      run_master(0, 1'b1, 1'b0, 32'h10, 32'h0);
      stall_n = 0;

      // m1 read+write together: only a write reaches the slave
      @(posedge clk); #1;
      rd0 = rd_cyc;
      wr0 = wr_cyc;
      push(1, 1'b1, 32'h3, 32'h33, 1);
      run_master(1, 1'b1, 1'b1, 32'h3, 32'h33);
      chk("rw_s0_read_cycles", rd_cyc - rd0, 0);
      chk("rw_s0_write_cycles", wr_cyc - wr0, 1);

      // Timeout on an m1 read: 4 stalled cycles then ABORT
      chk("pre_abort_flag", timeout_flag, 0);
      hang = 1'b1;
      @(posedge clk); #1;
      rd0 = rd_cyc;
      push(1, 1'b0, 32'h4, 32'hDEADBEEF, 5);
      run_master(1, 1'b1, 1'b0, 32'h4, 32'h0);
      hang = 1'b0;
      chk("abort_stall_cycles", rd_cyc - rd0, 4);
      @(negedge clk);
      chk("abort_timeout_flag", timeout_flag, 1);
      chk("abort_master", abort_master, 1);

      // Normal m0 read after the abort
      @(posedge clk); #1;
      push(0, 1'b0, 32'h10, 32'h12345678, 1);
      run_master(0, 1'b1, 1'b0, 32'h10, 32'h0);
      chk("post_abort_flag_sticky", timeout_flag, 1);

      // Reset during the 2nd stalled cycle of an m0 write
      hang = 1'b1;
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 32'h5, 32'h55);
      @(posedge clk); #1;                 // 1st stalled cycle
      @(negedge clk);
      chk("midrst_s0_write_before", s0_write, 1);
      @(posedge clk); #1;                 // 2nd stalled cycle
      reset = 1'b1;
      #1;
      chk("midrst_s0_write_drop", s0_write, 0);
      chk("midrst_m0_wait", m0_waitrequest, 1);
      drive(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      hang = 1'b0;
      @(negedge clk);
      chk("midrst_idle_s0_write", s0_write, 0);
      chk("midrst_idle_m0_wait", m0_waitrequest, 1);
      chk("midrst_timeout_flag", timeout_flag, 0);
      chk("midrst_abort_master", abort_master, 0);

      // last was 0 before reset; reset restores 1 so m0 wins again
      push(0, 1'b1, 32'h1, 32'hAA, 1);
      push(1, 1'b0, 32'h2, 32'hC0DE0002, 3);
      pair();

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/avmm_arbiter.md
# avmm_arbiter

Two-master round-robin arbiter sharing a single Avalon-MM slave port, such as the `program_logic` `s0_*` interface, between the UART host bridge (m0) and a second on-chip requester (m1). It sequences one transaction at a time to the slave and forwards the slave's waitrequest and readdata to the granted master. It also aborts transactions the slave stalls beyond a programmable timeout, so a hung program cannot deadlock the host link.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, read/write data width on all ports
- TIMEOUT, 1024, consecutive stalled grant cycles before abort; 0 disables the timeout
- ERROR_DATA, 32'hDEADBEEF, readdata returned on an aborted transaction

Ports:
- clk  in  1  single clock; all state is updated on the rising edge
- reset  in  1  synchronous, active-high
- m0_address / m1_address  in  ADDR_WIDTH  master address
- m0_read / m1_read  in  1  read request, held until waitrequest is low
- m0_write / m1_write  in  1  write request, held until waitrequest is low
- m0_writedata / m1_writedata  in  DATA_WIDTH  write data
- m0_readdata / m1_readdata  out  DATA_WIDTH  read data; valid in the completing cycle
- m0_waitrequest / m1_waitrequest  out  1  stall to master
- s0_address  out  ADDR_WIDTH  slave address
- s0_read / s0_write  out  1  slave strobes
- s0_writedata  out  DATA_WIDTH  slave write data
- s0_readdata  in  DATA_WIDTH  slave read data
- s0_waitrequest  in  1  slave stall
- timeout_flag  out  1  sticky; set on any abort, cleared only by reset
- abort_master  out  1  index of the master in the most recent abort; reset value 0

## Operation
- State machine: IDLE, GRANT0, GRANT1, ABORT. Registers: state, last (last-granted index, resets to 1), stall counter, timeout_flag, abort_master.
- A master is "requesting" when its read or write is high. If both read and write are high, the request is treated as a write and read is not forwarded.
- IDLE:
  - Only mX requesting → GRANTX.
  - Both requesting → grant the master != last.
  - Neither requesting → stay in IDLE.
- On entry to GRANTX: last is set to X and the stall counter is cleared.
- In GRANTX:
  - s0_address, s0_writedata and s0_read/s0_write are driven from mX (combinational mux).
  - mX_waitrequest = s0_waitrequest.
  - mX_readdata = s0_readdata.
  - The other master sees waitrequest = 1 and readdata = 0.
- Completion: mX request high and s0_waitrequest low → next state IDLE.
- Master drops its request while granted (protocol violation): next state IDLE, no slave strobe that cycle.
- Timeout (TIMEOUT > 0): the counter increments each grant cycle where s0_waitrequest is high. If the counter equals TIMEOUT-1 and s0_waitrequest is still high, the next state is ABORT.
- ABORT (one cycle):
  - s0_read/s0_write = 0.
  - mX_waitrequest = 0 and mX_readdata = ERROR_DATA.
  - timeout_flag is set and abort_master = X.
  - Next state IDLE.
- IDLE outputs: s0_read = s0_write = 0, s0_address = 0, s0_writedata = 0, both m waitrequest = 1, both readdata = 0.
- Counter width is $clog2(TIMEOUT+1), with a minimum of 1 bit. The counter saturates and never wraps.

## Timing
- Reset, synchronous: next edge forces state IDLE, last = 1, counter 0, timeout_flag 0, abort_master 0. While reset is high, all outputs take their IDLE values, including mid-transaction; the slave strobe drops combinationally with reset.
- Request first high in cycle t (state IDLE): grant is registered at t+1, and the slave sees the strobe in t+1.
- Zero-wait slave: the master completes in t+1, the arbiter is back in IDLE at t+2, and the next grant is at t+3. Peak throughput is one transaction per 2 cycles; a single request sees 1 cycle of arbitration latency.
- Slave stall of N cycles (N < TIMEOUT): the master completes in cycle t+1+N.
- Slave stalls indefinitely: stalled grant cycles are t+1 .. t+TIMEOUT, ABORT is at t+TIMEOUT+1, and the master completes that cycle.
- A simultaneous arrival of a new request and a completion cannot be granted in the same cycle; the new request waits for IDLE.
- A request held continuously by the losing master is granted right after the winner's transaction, so neither master starves.

## Test plan
- Reset values: after reset, m0/m1_waitrequest = 1, s0_read = s0_write = 0, timeout_flag = 0, abort_master = 0.
- Single read: m0 reads address 0x10, slave returns 0x12345678 with 0 wait states → s0_read high exactly 1 cycle and m0 sees readdata 0x12345678 with waitrequest low that cycle. With slave waitrequest high for 3 cycles → m0 completes exactly 3 cycles later.
- Simultaneous requests after reset: m0 write 0xAA to address 1 and m1 read address 2, both held → m0 granted first, then m1 after one IDLE cycle. Repeating with both held → m1 is granted first (alternation, since last = 0).
- Read+write asserted together by m1 → only s0_write is seen; s0_read stays 0 throughout.
- Timeout with TIMEOUT = 4: slave holds waitrequest high forever on an m1 read → exactly 4 stalled cycles, then m1_readdata = 32'hDEADBEEF with waitrequest low. Afterwards timeout_flag = 1 and abort_master = 1, and a subsequent m0 transaction proceeds normally.
- Reset mid-transaction: assert reset during the 2nd stalled cycle of an m0 write → s0_write falls that cycle, and after reset release the state is IDLE with last = 1.
